// File: rtl/bus_decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_decode_pkg
//  Description : Shared types for the 68000 registered bus decoder: bus-cycle
//                FSM state encoding, region table entry layout, PCB ids and
//                the region match helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_decode_pkg;

    // Field widths of a stored table entry (68000 byte address space).
    localparam int BD_ADDR_W  = 24;
    localparam int BD_WAIT_W  = 4;
    localparam int BD_WIDTH_W = $clog2(BD_ADDR_W + 1);

    // PCB variants held in the region table.
    localparam int PCB_TERRA_CRESTA = 0;
    localparam int PCB_AMAZON       = 1;
    localparam int PCB_HOREKID      = 2;

    typedef enum logic [2:0] {
        ST_RECOVER = 3'd0,
        ST_IDLE    = 3'd1,
        ST_DECODE  = 3'd2,
        ST_WAIT    = 3'd3,
        ST_ACK     = 3'd4,
        ST_NOHIT   = 3'd5
    } bus_state_e;

    typedef struct packed {
        logic                  valid;
        logic [BD_ADDR_W-1:0]  base;
        logic [BD_WIDTH_W-1:0] width;        // low address bits ignored
        logic [BD_WAIT_W-1:0]  wait_states;  // extra clocks before DTACK
    } region_entry_t;

    // width == BD_ADDR_W shifts both sides to zero, so the region covers
    // the whole address space.
    function automatic logic entry_match(input region_entry_t e,
                                         input logic [BD_ADDR_W-1:0] addr);
        return e.valid && ((addr >> e.width) == (e.base >> e.width));
    endfunction

endpackage : bus_decode_pkg
`default_nettype wire

// File: rtl/bus_region_table.sv
`default_nettype none
// ============================================================================
//  Module      : bus_region_table
//  Description : NUM_PCB x NUM_REGIONS region register file with one write
//                port and a combinational lowest-index priority match port.
//  Revision    : 1.0 - initial release
//  Ports       : clk_sys/reset            clock, sync active-high reset
//                cfg_*_i                  table write port
//                rd_pcb_i, rd_addr_i      match lookup inputs
//                match_hit_o/idx_o/wait_o lowest matching entry
// ============================================================================
module bus_region_table
    import bus_decode_pkg::*;
#(
    parameter int NUM_REGIONS = 16,
    parameter int NUM_PCB     = 4,
    parameter int ADDR_W      = BD_ADDR_W,
    parameter int WAIT_W      = BD_WAIT_W
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic                           cfg_we_i,
    input  logic [$clog2(NUM_PCB)-1:0]     cfg_pcb_i,
    input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx_i,
    input  logic [ADDR_W-1:0]              cfg_base_i,
    input  logic [$clog2(ADDR_W+1)-1:0]    cfg_width_i,
    input  logic [WAIT_W-1:0]              cfg_wait_i,
    input  logic                           cfg_valid_i,
    input  logic [$clog2(NUM_PCB)-1:0]     rd_pcb_i,
    input  logic [ADDR_W-1:0]              rd_addr_i,
    output logic                           match_hit_o,
    output logic [$clog2(NUM_REGIONS)-1:0] match_idx_o,
    output logic [WAIT_W-1:0]              match_wait_o
);

    localparam int IDX_W = $clog2(NUM_REGIONS);

    region_entry_t entry_q [NUM_PCB][NUM_REGIONS];
    region_entry_t wr_entry;

    always_comb begin
        wr_entry             = '0;
        wr_entry.valid       = cfg_valid_i;
        wr_entry.base        = cfg_base_i;
        wr_entry.width       = cfg_width_i;
        wr_entry.wait_states = cfg_wait_i;
    end

    // A write lands at the clock edge, so a lookup in the same cycle still
    // sees the previous contents of the entry.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            for (int p = 0; p < NUM_PCB; p++) begin
                for (int r = 0; r < NUM_REGIONS; r++) begin
                    entry_q[p][r] <= '0;
                end
            end
        end else if (cfg_we_i) begin
            entry_q[cfg_pcb_i][cfg_idx_i] <= wr_entry;
        end
    end

    // Scan from the top so the lowest matching index is the last to assign.
    always_comb begin
        match_hit_o  = 1'b0;
        match_idx_o  = '0;
        match_wait_o = '0;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (entry_match(entry_q[rd_pcb_i][r], rd_addr_i)) begin
                match_hit_o  = 1'b1;
                match_idx_o  = IDX_W'(r);
                match_wait_o = entry_q[rd_pcb_i][r].wait_states;
            end
        end
    end

endmodule : bus_region_table
`default_nettype wire

// File: rtl/m68k_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : m68k_bus_decoder
//  Description : Registered 68000 address decoder. Per-PCB programmable region
//                table plus a bus-cycle FSM that latches a one-hot select when
//                AS is sampled low and generates DTACK_n after the region's
//                wait states.
//  Revision    : 1.0 - initial release
//  Macro       : BUS_DECODE_BERR_EN - enables the no-hit bus error timeout
//  Ports       : clk_sys, reset            clock, sync active-high reset
//                pcb                       active PCB set (used in DECODE)
//                m68k_a, m68k_as_n         68000 address / address strobe
//                cfg_*                     region table write port
//                cs, hit, region_idx       registered select outputs
//                dtack_n, berr_n           68000 cycle termination
// ============================================================================
module m68k_bus_decoder
    import bus_decode_pkg::*;
#(
    parameter int NUM_REGIONS = 16,
    parameter int NUM_PCB     = 4,
    parameter int ADDR_W      = 24,
    parameter int WAIT_W      = 4,
    parameter int BERR_CYCLES = 64
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic [$clog2(NUM_PCB)-1:0]     pcb,
    input  logic [ADDR_W-1:0]              m68k_a,
    input  logic                           m68k_as_n,
    input  logic                           cfg_we,
    input  logic [$clog2(NUM_PCB)-1:0]     cfg_pcb,
    input  logic [$clog2(NUM_REGIONS)-1:0] cfg_idx,
    input  logic [ADDR_W-1:0]              cfg_base,
    input  logic [$clog2(ADDR_W+1)-1:0]    cfg_width,
    input  logic [WAIT_W-1:0]              cfg_wait,
    input  logic                           cfg_valid,
    output logic [NUM_REGIONS-1:0]         cs,
    output logic                           hit,
    output logic [$clog2(NUM_REGIONS)-1:0] region_idx,
    output logic                           dtack_n,
    output logic                           berr_n
);

    localparam int IDX_W = $clog2(NUM_REGIONS);

    logic              match_hit;
    logic [IDX_W-1:0]  match_idx;
    logic [WAIT_W-1:0] match_wait;

    bus_state_e              state_q, state_d;
    logic [NUM_REGIONS-1:0]  cs_q, cs_d;
    logic                    hit_q, hit_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    dtack_n_q, dtack_n_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;

    bus_region_table #(
        .NUM_REGIONS (NUM_REGIONS),
        .NUM_PCB     (NUM_PCB),
        .ADDR_W      (ADDR_W),
        .WAIT_W      (WAIT_W)
    ) u_table (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .cfg_we_i     (cfg_we),
        .cfg_pcb_i    (cfg_pcb),
        .cfg_idx_i    (cfg_idx),
        .cfg_base_i   (cfg_base),
        .cfg_width_i  (cfg_width),
        .cfg_wait_i   (cfg_wait),
        .cfg_valid_i  (cfg_valid),
        .rd_pcb_i     (pcb),
        .rd_addr_i    (m68k_a),
        .match_hit_o  (match_hit),
        .match_idx_o  (match_idx),
        .match_wait_o (match_wait)
    );

`ifdef BUS_DECODE_BERR_EN
    localparam int BERR_CNT_W = $clog2(BERR_CYCLES + 1);
    logic [BERR_CNT_W-1:0] berr_cnt_q, berr_cnt_d;
    logic                  berr_n_q, berr_n_d;
`endif

    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        hit_d     = hit_q;
        idx_d     = idx_q;
        dtack_n_d = dtack_n_q;
        wait_d    = wait_q;
`ifdef BUS_DECODE_BERR_EN
        berr_cnt_d = berr_cnt_q;
        berr_n_d   = berr_n_q;
`endif
        case (state_q)
            // Wait for AS high so a strobe already low at reset release is
            // never decoded half-way through.
            ST_RECOVER: if (m68k_as_n) state_d = ST_IDLE;
            ST_IDLE:    if (!m68k_as_n) state_d = ST_DECODE;
            ST_DECODE: begin
                if (m68k_as_n) begin
                    state_d = ST_IDLE;
                end else if (match_hit) begin
                    cs_d    = NUM_REGIONS'(1) << match_idx;
                    hit_d   = 1'b1;
                    idx_d   = match_idx;
                    wait_d  = match_wait;
                    state_d = (match_wait == '0) ? ST_ACK : ST_WAIT;
                end else begin
                    state_d = ST_NOHIT;
`ifdef BUS_DECODE_BERR_EN
                    berr_cnt_d = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (m68k_as_n) begin
                    cs_d    = '0;
                    hit_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q - 1'b1;
                    if (wait_q == WAIT_W'(1)) state_d = ST_ACK;
                end
            end
            // DTACK is registered here, so it appears one clock after entry.
            ST_ACK: begin
                if (m68k_as_n) begin
                    cs_d      = '0;
                    hit_d     = 1'b0;
                    idx_d     = '0;
                    dtack_n_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    dtack_n_d = 1'b0;
                end
            end
            ST_NOHIT: begin
                if (m68k_as_n) state_d = ST_IDLE;
`ifdef BUS_DECODE_BERR_EN
                if (m68k_as_n)
                    berr_n_d = 1'b1;
                else if (berr_cnt_q == BERR_CNT_W'(BERR_CYCLES - 1))
                    berr_n_d = 1'b0;
                else
                    berr_cnt_d = berr_cnt_q + 1'b1;
`endif
            end
            default: state_d = ST_RECOVER;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q   <= ST_RECOVER;
            cs_q      <= '0;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            dtack_n_q <= 1'b1;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            hit_q     <= hit_d;
            idx_q     <= idx_d;
            dtack_n_q <= dtack_n_d;
            wait_q    <= wait_d;
        end
    end

`ifdef BUS_DECODE_BERR_EN
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            berr_cnt_q <= '0;
            berr_n_q   <= 1'b1;
        end else begin
            berr_cnt_q <= berr_cnt_d;
            berr_n_q   <= berr_n_d;
        end
    end
    assign berr_n = berr_n_q;
`else
    // No timeout: a no-hit cycle hangs the CPU as on the original board.
    // The expression folds to a constant 1 while keeping BERR_CYCLES bound.
    assign berr_n = 1'b1 | (BERR_CYCLES == 0);
`endif

    assign cs         = cs_q;
    assign hit        = hit_q;
    assign region_idx = idx_q;
    assign dtack_n    = dtack_n_q;

endmodule : m68k_bus_decoder
`default_nettype wire

// File: tb/tb_m68k_bus_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m68k_bus_decoder
//  Description : Directed bench for m68k_bus_decoder: vector table of bus
//                reads plus hand-written reset/abort/table-write sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m68k_bus_decoder;

    localparam int NR = 16;
    localparam int NP = 4;
    localparam int AW = 24;
    localparam int WW = 4;
    localparam int BC = 64;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [1:0]    pcb;
    logic [AW-1:0] m68k_a;
    logic          m68k_as_n;
    logic          cfg_we;
    logic [1:0]    cfg_pcb;
    logic [3:0]    cfg_idx;
    logic [AW-1:0] cfg_base;
    logic [4:0]    cfg_width;
    logic [WW-1:0] cfg_wait;
    logic          cfg_valid;
    logic [NR-1:0] cs;
    logic          hit;
    logic [3:0]    region_idx;
    logic          dtack_n;
    logic          berr_n;

    m68k_bus_decoder #(
        .NUM_REGIONS (NR), .NUM_PCB (NP), .ADDR_W (AW),
        .WAIT_W (WW), .BERR_CYCLES (BC)
    ) dut (
        .clk_sys (clk_sys), .reset (reset), .pcb (pcb), .m68k_a (m68k_a),
        .m68k_as_n (m68k_as_n), .cfg_we (cfg_we), .cfg_pcb (cfg_pcb),
        .cfg_idx (cfg_idx), .cfg_base (cfg_base), .cfg_width (cfg_width),
        .cfg_wait (cfg_wait), .cfg_valid (cfg_valid), .cs (cs), .hit (hit),
        .region_idx (region_idx), .dtack_n (dtack_n), .berr_n (berr_n)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one table write; inputs change just after a falling edge.
    task automatic cfg(input int p, input int i, input logic [AW-1:0] b,
                       input int w, input int wt, input logic v);
        cfg_we    = 1'b1;
        cfg_pcb   = 2'(p);
        cfg_idx   = 4'(i);
        cfg_base  = b;
        cfg_width = 5'(w);
        cfg_wait  = WW'(wt);
        cfg_valid = v;
        @(negedge clk_sys);
        cfg_we = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    pcb;
        logic [AW-1:0] addr;
        logic          hit;
        logic [3:0]    idx;
        int            wt;
    } vec_t;

    function automatic logic [NR-1:0] onehot(input logic [3:0] idx);
        logic [NR-1:0] one;
        one = 1;
        return one << idx;
    endfunction

    // Full bus cycle. Edge N samples AS low; cs must appear after N+1 and
    // DTACK after N+2+wait, i.e. wait+1 falling edges past the cs check.
    task automatic run_cycle(input vec_t v, input string tag);
        int k;
        pcb       = v.pcb;
        m68k_a    = v.addr;
        m68k_as_n = 1'b0;
        @(negedge clk_sys);
        chk({tag, "/cs_early"}, 32'(cs), 32'd0);
        @(negedge clk_sys);
        chk({tag, "/cs"},  32'(cs), v.hit ? 32'(onehot(v.idx)) : 32'd0);
        chk({tag, "/hit"}, 32'(hit), 32'(v.hit));
        chk({tag, "/idx"}, 32'(region_idx), v.hit ? 32'(v.idx) : 32'd0);
        k = 0;
        if (v.hit) begin
            while (dtack_n && k < 40) begin
                @(negedge clk_sys);
                k++;
            end
            chk({tag, "/dtack_lat"}, 32'(k), 32'(v.wt + 1));
            chk({tag, "/cs_hold"}, 32'(cs), 32'(onehot(v.idx)));
        end else begin
            while (berr_n && k < BC + 10) begin
                @(negedge clk_sys);
                k++;
            end
`ifdef BUS_DECODE_BERR_EN
            chk({tag, "/berr_lat"}, 32'(k), 32'(BC));
`else
            chk({tag, "/berr_never"}, 32'(k), 32'(BC + 10));
`endif
            chk({tag, "/nohit_dtack"}, 32'(dtack_n), 32'd1);
        end
        m68k_as_n = 1'b1;
        @(negedge clk_sys);
        chk({tag, "/end_cs"},    32'(cs), 32'd0);
        chk({tag, "/end_hit"},   32'(hit), 32'd0);
        chk({tag, "/end_dtack"}, 32'(dtack_n), 32'd1);
        chk({tag, "/end_berr"},  32'(berr_n), 32'd1);
        @(negedge clk_sys);
    endtask

    vec_t vecs [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        vec_t v0;
        // idx2 uses width 14 so it genuinely overlaps idx5 around 0x022010.
        vecs[0]  = '{2'd0, 24'h01FFFE, 1'b1, 4'd0, 0};
        vecs[1]  = '{2'd0, 24'h022010, 1'b1, 4'd2, 1};
        vecs[2]  = '{2'd0, 24'h021000, 1'b1, 4'd2, 1};
        vecs[3]  = '{2'd0, 24'h020000, 1'b1, 4'd2, 1};
        vecs[4]  = '{2'd0, 24'h04ABCD, 1'b1, 4'd3, 5};
        vecs[5]  = '{2'd0, 24'h0F0000, 1'b0, 4'd0, 0};
        vecs[6]  = '{2'd0, 24'h100000, 1'b1, 4'd9, 0};
        vecs[7]  = '{2'd0, 24'h100001, 1'b0, 4'd0, 0};
        vecs[8]  = '{2'd1, 24'h123456, 1'b1, 4'd1, 2};
        vecs[9]  = '{2'd1, 24'h0F0000, 1'b1, 4'd1, 2};
        vecs[10] = '{2'd2, 24'h000000, 1'b0, 4'd0, 0};
        vecs[11] = '{2'd0, 24'h000000, 1'b1, 4'd0, 0};

        reset = 1'b1; pcb = 2'd0; m68k_a = '0; m68k_as_n = 1'b0;
        cfg_we = 1'b0; cfg_pcb = '0; cfg_idx = '0; cfg_base = '0;
        cfg_width = '0; cfg_wait = '0; cfg_valid = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst/cs",    32'(cs), 32'd0);
        chk("rst/hit",   32'(hit), 32'd0);
        chk("rst/idx",   32'(region_idx), 32'd0);
        chk("rst/dtack", 32'(dtack_n), 32'd1);
        chk("rst/berr",  32'(berr_n), 32'd1);

        // Release reset with AS still low; region 0 is written at once, so a
        // decoder that skipped the recovery wait would select it.
        m68k_a = 24'h01FFFE;
        reset  = 1'b0;
        cfg(0, 0, 24'h000000, 17, 0, 1'b1);
        seen = 0;
        repeat (5) begin
            @(negedge clk_sys);
            if (cs != '0 || hit || !dtack_n) seen++;
        end
        chk("recover/no_select", 32'(seen), 32'd0);
        m68k_as_n = 1'b1;
        @(negedge clk_sys);
        run_cycle(vecs[0], "first");

        cfg(0, 2, 24'h020000, 14, 1, 1'b1);
        cfg(0, 5, 24'h022000, 12, 0, 1'b1);
        cfg(0, 3, 24'h040000, 16, 5, 1'b1);
        cfg(0, 7, 24'h0F0000, 16, 0, 1'b0);
        cfg(0, 9, 24'h100000, 0, 0, 1'b1);
        cfg(1, 1, 24'h800000, 24, 2, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_cycle(vecs[i], $sformatf("vec%0d", i));
        end

        // Abort: AS released while waiting; DTACK must never assert.
        pcb = 2'd0; m68k_a = 24'h04ABCD; m68k_as_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("abort/cs_set", 32'(cs), 32'h8);
        @(negedge clk_sys);
        m68k_as_n = 1'b1;
        @(negedge clk_sys);
        chk("abort/cs_clr",  32'(cs), 32'd0);
        chk("abort/hit_clr", 32'(hit), 32'd0);
        seen = 0;
        repeat (8) begin
            @(negedge clk_sys);
            if (!dtack_n) seen++;
        end
        chk("abort/no_dtack", 32'(seen), 32'd0);
        run_cycle(vecs[0], "after_abort");

        // Table write in the DECODE clock to the entry being read: the old
        // contents decide this cycle, the new ones the next.
        pcb = 2'd0; m68k_a = 24'h01FFFE; m68k_as_n = 1'b0;
        @(negedge clk_sys);
        cfg(0, 0, 24'h000000, 17, 0, 1'b0);
        chk("wrdec/old_entry", 32'(cs), 32'h1);
        seen = 0;
        while (dtack_n && seen < 40) begin
            @(negedge clk_sys);
            seen++;
        end
        chk("wrdec/dtack", 32'(dtack_n), 32'd0);
        m68k_as_n = 1'b1;
        repeat (2) @(negedge clk_sys);
        v0 = vecs[0];
        v0.hit = 1'b0;
        run_cycle(v0, "wrdec_new");
        cfg(0, 0, 24'h000000, 17, 0, 1'b1);

        // Reset in the middle of a cycle with AS held low.
        pcb = 2'd0; m68k_a = 24'h04ABCD; m68k_as_n = 1'b0;
        repeat (2) @(negedge clk_sys);
        chk("midrst/cs_set", 32'(cs), 32'h8);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("midrst/cs",    32'(cs), 32'd0);
        chk("midrst/hit",   32'(hit), 32'd0);
        chk("midrst/dtack", 32'(dtack_n), 32'd1);
        reset = 1'b0;
        cfg(0, 3, 24'h040000, 16, 5, 1'b1);
        seen = 0;
        repeat (4) begin
            @(negedge clk_sys);
            if (cs != '0 || !dtack_n) seen++;
        end
        chk("midrst/recover", 32'(seen), 32'd0);
        m68k_as_n = 1'b1;
        @(negedge clk_sys);
        run_cycle(vecs[4], "midrst_next");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_m68k_bus_decoder
`default_nettype wire
